// File: rtl/ds_dac.sv
// First-order delta-sigma DAC: emits exactly "code" ones per 2^WIDTH-clock frame,
// with a double-buffered code that only switches on frame boundaries.
module ds_dac #(
  parameter int WIDTH = 10
) (
  input  logic             i_clk,
  input  logic             i_res_n,
  input  logic             i_dac_en,
  input  logic [WIDTH-1:0] i_dac_val,
  input  logic             i_dac_load,
  output logic             o_dac_out,
  output logic [WIDTH-1:0] o_dac_cur,
  output logic             o_dac_pend,
  output logic             o_dac_frame
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic             pend_vld_q, pend_vld_d;
  logic             out_q, out_d;
  logic             frame_q, frame_d;
  logic [WIDTH:0]   sum;
  logic             frame_end;

  always_comb begin
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    pend_d     = pend_q;
    cur_d      = cur_q;
    pend_vld_d = pend_vld_q;
    out_d      = out_q;
    frame_d    = frame_q;
    sum        = {1'b0, acc_q} + {1'b0, cur_q};
    frame_end  = (cnt_q == '1);

    if (i_dac_en) begin
      out_d = sum[WIDTH];
      cnt_d = cnt_q + 1'b1;
      if (frame_end) begin
        // Clearing acc keeps every frame independent of any code change.
        acc_d   = '0;
        frame_d = 1'b1;
        if (pend_vld_q) begin
          cur_d      = pend_q;
          pend_vld_d = 1'b0;
        end
      end else begin
        acc_d   = sum[WIDTH-1:0];
        frame_d = 1'b0;
      end
      // A load on the boundary edge lands in the buffer after the swap above.
      if (i_dac_load) begin
        pend_d     = i_dac_val;
        pend_vld_d = 1'b1;
      end
    end else begin
      cnt_d      = '0;
      acc_d      = '0;
      out_d      = 1'b0;
      frame_d    = 1'b0;
      pend_vld_d = 1'b0;
      if (i_dac_load) begin
        cur_d = i_dac_val;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      pend_q     <= '0;
      cur_q      <= '0;
      pend_vld_q <= 1'b0;
      out_q      <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      pend_q     <= pend_d;
      cur_q      <= cur_d;
      pend_vld_q <= pend_vld_d;
      out_q      <= out_d;
      frame_q    <= frame_d;
    end
  end

  assign o_dac_out   = out_q;
  assign o_dac_cur   = cur_q;
  assign o_dac_pend  = pend_vld_q;
  assign o_dac_frame = frame_q;

endmodule

// File: tb/tb_ds_dac.sv
// Directed bench for ds_dac: per-frame ones counts are queued when a code is
// scheduled and popped when the frame has been observed.
module tb_ds_dac;
  localparam int W = 10;
  localparam int N = 1 << W;

  logic         clk = 1'b0;
  logic         res_n = 1'b0;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] val = '0;
  logic         dac_out;
  logic [W-1:0] dac_cur;
  logic         dac_pend;
  logic         dac_frame;

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int ones, pulses, alt_bad, first_bit;

  ds_dac #(.WIDTH(W)) dut (
    .i_clk      (clk),
    .i_res_n    (res_n),
    .i_dac_en   (en),
    .i_dac_val  (val),
    .i_dac_load (load),
    .o_dac_out  (dac_out),
    .o_dac_cur  (dac_cur),
    .o_dac_pend (dac_pend),
    .o_dac_frame(dac_frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dis_load(input int v);
    load = 1'b1;
    val  = W'(v);
    tick();
    load = 1'b0;
  endtask

  // One full frame from the cnt=0 edge to the cnt=N-1 edge, with up to two loads.
  task automatic run_frame(input string tag, input int la, input int va,
                           input int lb, input int vb);
    int e;
    ones = 0; pulses = 0; alt_bad = 0; first_bit = 0;
    for (int k = 0; k < N; k++) begin
      if (k == la) begin
        load = 1'b1; val = W'(va);
      end else if (k == lb) begin
        load = 1'b1; val = W'(vb);
      end
      tick();
      load = 1'b0;
      if (k == la) chk({tag, " pend after load"}, 32'(dac_pend), 1);
      ones += int'(dac_out);
      if (k == 0) first_bit = int'(dac_out);
      if (int'(dac_out) != (k % 2)) alt_bad++;
      if (k < N - 1 && dac_frame) pulses++;
    end
    if (exp_q.size() == 0) begin
      chk({tag, " scoreboard empty"}, 32'(exp_q.size()), 1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, " ones"}, 32'(ones), 32'(e));
    end
    chk({tag, " frame pulse at end"}, 32'(dac_frame), 1);
    chk({tag, " no early pulse"}, 32'(pulses), 0);
  endtask

  initial begin
    int codes[4] = '{512, 1, 1023, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst out", 32'(dac_out), 0);
    chk("rst cur", 32'(dac_cur), 0);
    chk("rst pend", 32'(dac_pend), 0);
    chk("rst frame", 32'(dac_frame), 0);
    res_n = 1'b1;
    tick();

    // Exact density for boundary and mid codes
    foreach (codes[i]) begin
      en = 1'b0;
      tick();
      dis_load(codes[i]);
      chk($sformatf("dis load cur %0d", codes[i]), 32'(dac_cur), 32'(codes[i]));
      chk($sformatf("dis load pend %0d", codes[i]), 32'(dac_pend), 0);
      exp_q.push_back(codes[i]);
      en = 1'b1;
      run_frame($sformatf("density %0d", codes[i]), -1, 0, -1, 0);
      if (codes[i] == 512) chk("512 alternation errors", 32'(alt_bad), 0);
      if (codes[i] == 1023) chk("1023 first bit", 32'(first_bit), 0);
    end

    // Double buffer: load mid-frame, switch at boundary
    en = 1'b0;
    tick();
    dis_load(100);
    exp_q.push_back(100);
    en = 1'b1;
    run_frame("dbuf", 300, 700, -1, 0);
    chk("dbuf cur", 32'(dac_cur), 700);
    chk("dbuf pend", 32'(dac_pend), 0);

    // Collision: 200 pending, 900 loaded on the boundary edge
    exp_q.push_back(700);
    run_frame("coll a", 10, 200, N - 1, 900);
    chk("coll cur", 32'(dac_cur), 200);
    chk("coll pend", 32'(dac_pend), 1);
    exp_q.push_back(200);
    run_frame("coll b", -1, 0, -1, 0);
    chk("coll cur next", 32'(dac_cur), 900);
    chk("coll pend next", 32'(dac_pend), 0);

    // Overwrite: last of two loads wins
    exp_q.push_back(900);
    run_frame("ovw a", 5, 50, 500, 60);
    chk("ovw cur", 32'(dac_cur), 60);
    exp_q.push_back(60);
    run_frame("ovw b", -1, 0, -1, 0);

    // Loopback-style: code 333 every frame, pulses exactly once per 1024 clks
    en = 1'b0;
    tick();
    dis_load(333);
    en = 1'b1;
    exp_q.push_back(333);
    exp_q.push_back(333);
    run_frame("loop 1", -1, 0, -1, 0);
    run_frame("loop 2", -1, 0, -1, 0);

    // Mid-operation async reset with a pending code
    load = 1'b1; val = W'(444);
    tick();
    load = 1'b0;
    repeat (100) tick();
    chk("pre-rst cur", 32'(dac_cur), 333);
    chk("pre-rst pend", 32'(dac_pend), 1);
    #2;
    res_n = 1'b0;
    #1;
    chk("async rst out", 32'(dac_out), 0);
    chk("async rst cur", 32'(dac_cur), 0);
    chk("async rst pend", 32'(dac_pend), 0);
    chk("async rst frame", 32'(dac_frame), 0);
    tick();
    res_n = 1'b1;
    ones = 0;
    for (int k = 0; k < N + 76; k++) begin
      tick();
      ones += int'(dac_out);
    end
    chk("post-rst ones", 32'(ones), 0);
    chk("post-rst cur", 32'(dac_cur), 0);
    chk("post-rst pend", 32'(dac_pend), 0);
    chk("scoreboard drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ds_dac.md
Name: ds_dac

Overview:
- First-order delta-sigma DAC. Converts a WIDTH-bit code into a 1-bit pulse-density stream on an output pin; an external RC filter recovers the analogue level.
- Frames are 2^WIDTH clocks long, matching the delta-sigma ADC integration window. Each frame emits exactly "code" ones.
- Companion to the ADC: use it as a loopback or reference source.
- Code updates are double-buffered and take effect only on frame boundaries.

Parameters:
- WIDTH, 10, code width; frame length N = 2^WIDTH clocks.

Ports:
- i_clk  input  1  system clock
- i_res_n  input  1  asynchronous active-low reset
- i_dac_en  input  1  run enable; low = idle, output held 0
- i_dac_val  input  WIDTH  new code, sampled when i_dac_load=1
- i_dac_load  input  1  1-clk load strobe
- o_dac_out  output  1  PDM bit stream (registered)
- o_dac_cur  output  WIDTH  code currently being modulated
- o_dac_pend  output  1  a loaded code is waiting for the next frame boundary
- o_dac_frame  output  1  positive 1-clk pulse: first output bit of a new frame follows

Behaviour:
- Reset (async, i_res_n=0): cnt=0, acc=0, o_dac_cur=0, pend=0, o_dac_pend=0, o_dac_out=0, o_dac_frame=0.

Internal registers:
- cnt, WIDTH bits, free-running wrap 2^WIDTH-1 -> 0.
- acc, WIDTH bits.
- pend, WIDTH bits.

Enabled edge (i_dac_en=1):
- sum = {1'b0,acc} + {1'b0,o_dac_cur}, WIDTH+1 bits.
- o_dac_out <= sum[WIDTH].
- cnt <= cnt+1.
- If cnt != 2^WIDTH-1:
  - acc <= sum[WIDTH-1:0]
  - o_dac_frame <= 0
- If cnt == 2^WIDTH-1 (frame end):
  - acc <= 0
  - o_dac_frame <= 1
  - if o_dac_pend: o_dac_cur <= pend and o_dac_pend <= 0
- Result: bits registered on edges cnt=0..2^WIDTH-1 contain exactly o_dac_cur ones.
  - Code 0 gives all zeros.
  - Code 2^WIDTH-1 gives one 0 per frame, in the first bit of the frame.
  - Ones are evenly spread (first-order pattern).

Load handling, enabled:
- i_dac_load=1 -> pend <= i_dac_val, o_dac_pend <= 1.
- Repeated loads before the boundary overwrite: last wins.
- Load on the same edge as frame end: the old pend (if valid) is applied to o_dac_cur. The new value goes to pend with o_dac_pend=1, and is applied at the following boundary.
- A load when nothing is pending at frame end is not applied until the next boundary.

Disabled edge (i_dac_en=0):
- cnt <= 0, acc <= 0, o_dac_out <= 0, o_dac_frame <= 0.
- i_dac_load writes o_dac_cur directly.
- Any existing pending value is discarded, o_dac_pend <= 0.

Enable rising:
- The first enabled edge has cnt=0 and starts a frame with the current o_dac_cur.
- No o_dac_frame pulse for this first frame.

Latency:
- o_dac_out is 1 clk after the accumulate.
- A code loaded while enabled takes effect 1..2^WIDTH clks later, always at a boundary.

Mid-operation reset:
- Immediate async clear to the reset values.
- The pending code is lost.

Test Plan:
- Reset: assert i_res_n=0 mid-stream -> all outputs 0 immediately; after release with i_dac_en=1, output stays 0 (code 0).
- Exact density: disabled load 512, enable, count o_dac_out over 1024 clks from the first enabled edge -> 512 ones, strictly alternating 0/1. Repeat with 1, 1023, 0 -> 1, 1023, 0 ones.
- Double-buffer: running code 100; load 700 at cnt=300 -> o_dac_pend=1. The rest of that frame still totals 100 ones. o_dac_frame pulses, o_dac_cur=700, o_dac_pend=0, the next frame has 700 ones.
- Collision: pend=200 valid; load 900 on the cnt=1023 edge -> o_dac_cur=200, o_dac_pend=1 (900). The frame after next uses 900.
- Overwrite: two loads, 50 then 60, in the same frame -> the next frame uses 60 (60 ones).
- Loopback: drive the ADC comparator input with o_dac_out, frames aligned, code 333 -> ADC reports 333 every frame; o_dac_frame period = 1024 clks.
